// File: rtl/demux_4_seq.sv
// demux_4_seq: registered 1-to-4 distributor with addressed and round-robin lane selection
module demux_4_seq #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_in,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_s,
  input  logic         i_mode,
  output logic [N-1:0] o_out0,
  output logic [N-1:0] o_out1,
  output logic [N-1:0] o_out2,
  output logic [N-1:0] o_out3,
  output logic [3:0]   o_valid,
  input  logic [3:0]   i_ack,
  output logic [1:0]   o_ptr
);
  logic [N-1:0] r_out [4];
  logic [3:0]   r_valid;
  logic [1:0]   r_ptr;
  logic [1:0]   w_tgt;
  logic         w_accept;
  logic [3:0]   w_sel;
  // target lane, readiness and one-hot write strobe; i_valid gates the strobe so don't-care data cannot disturb state
  always_comb begin
    w_tgt    = i_mode ? r_ptr : i_s;
    o_ready  = !r_valid[w_tgt] | i_ack[w_tgt];
    w_accept = i_valid & o_ready;
    w_sel    = w_accept ? (4'b0001 << w_tgt) : 4'b0000;
  end
  // valid flags drop on ack unless the same lane is refilled; pointer advances only on round-robin accepts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 4'b0000;
      r_ptr   <= 2'd0;
    end else begin
      r_valid <= (r_valid & ~i_ack) | w_sel;
      r_ptr   <= r_ptr + {1'b0, w_accept & i_mode};
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_lane
    // holding register keeps its word after ack; only a new accept overwrites it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_out[k] <= '0;
      else if (w_sel[k]) r_out[k] <= i_in;
    end
  end
  assign o_out0  = r_out[0];
  assign o_out1  = r_out[1];
  assign o_out2  = r_out[2];
  assign o_out3  = r_out[3];
  assign o_valid = r_valid;
  assign o_ptr   = r_ptr;
endmodule

// File: doc/demux_4_seq.md
Name: demux_4_seq

Overview:
- Registered 1-to-4 distributor. It is the inverse of the 4-way word selector.
- Accepts N-bit words on a valid/ready input and steers each word into one of four holding registers.
- In addressed mode the lane is taken from the select input. In round-robin mode it comes from an internal lane pointer.
- Each output lane presents its word with a valid flag until the consumer acknowledges it. Used to fan a single datapath result out to four register or unit ports.

Parameters:
- N, 64, data width of input word and of each output lane

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_in  input  N  input data word
- i_valid  input  1  i_in holds a word to transfer
- o_ready  output  1  block can accept a word this cycle (combinational)
- i_s  input  2  target lane in addressed mode; ignored in round-robin mode
- i_mode  input  1  0 = addressed, 1 = round-robin
- o_out0  output  N  lane 0 holding register
- o_out1  output  N  lane 1 holding register
- o_out2  output  N  lane 2 holding register
- o_out3  output  N  lane 3 holding register
- o_valid  output  4  o_valid[k] = lane k holds an unconsumed word
- i_ack  input  4  i_ack[k] = consumer takes lane k this cycle
- o_ptr  output  2  current round-robin lane pointer (debug/status)

Behaviour:
- Reset (i_rst_n = 0, asynchronous, effective immediately):
  - o_out0..o_out3 = 0, o_valid = 4'b0000, o_ptr = 0.
  - The block stays in reset while i_rst_n is low.
  - A reset asserted mid-transfer discards all held words. No partial state survives.
- Target lane:
  - tgt = i_s when i_mode = 0.
  - tgt = o_ptr when i_mode = 1.
- Readiness: o_ready = !o_valid[tgt] | i_ack[tgt].
  - A full lane can be refilled in the same cycle it is acknowledged.
  - o_ready depends combinationally on i_s, i_mode, o_ptr, o_valid, i_ack. There is no path from i_valid to o_ready.
- Accept: accept = i_valid & o_ready. On the edge with accept:
  - out[tgt] <= i_in and o_valid[tgt] <= 1.
  - Latency is 1 cycle: the word appears on the lane in the cycle after acceptance.
- Ack: on an edge with i_ack[k] = 1 and no accept into lane k:
  - o_valid[k] <= 0.
  - out[k] keeps its last value; data is not cleared.
- Ack on an empty lane (o_valid[k] = 0) has no effect.
- Acks to several lanes in one cycle are each honoured independently.
- Accept and ack on the same lane in the same cycle: o_valid[k] stays 1 and out[k] takes the new word.
- Blocked input: i_valid = 1 with o_ready = 0 transfers nothing. The producer must hold i_in, i_s and i_mode stable until accepted.
- Round-robin pointer:
  - o_ptr <= o_ptr + 1 (mod 4, 3 wraps to 0) only on an accept with i_mode = 1.
  - In addressed mode o_ptr holds.
  - Switching modes never alters o_ptr; round-robin resumes from the held pointer.
- Round-robin stall: if lane o_ptr is full and not acked, the block stalls. It never skips ahead to a free lane; strict order is guaranteed.
- Lanes other than tgt are unaffected by an accept.
- X-safety: i_s and i_in are don't-care when i_valid = 0. State must not change on them.

Test Plan:
- Reset:
  - Drive i_rst_n = 0 mid-cycle with lanes loaded → o_valid = 0000, all o_out = 0, o_ptr = 0 immediately, with no clock edge required.
- Addressed fill:
  - i_mode = 0; send 0xA0, 0xA1, 0xA2, 0xA3 with i_s = 2, 0, 3, 1 → next cycle after each accept the matching lane holds the word; final o_out2 = 0xA0, o_out0 = 0xA1, o_out3 = 0xA2, o_out1 = 0xA3; o_valid = 1111; o_ptr = 0.
  - Then a fifth word with i_s = 1 and no ack → o_ready = 0; no change.
- Same-cycle refill:
  - Lane 1 full with 0x11; i_valid = 1, i_s = 1, i_in = 0x22, i_ack = 0010 → o_ready = 1; next cycle o_out1 = 0x22, o_valid[1] = 1.
- Round-robin wrap:
  - i_mode = 1 from o_ptr = 0; consumer acks every lane each cycle; send 6 words 0x1..0x6 → lanes receive 0,1,2,3,0,1 in order; o_ptr ends at 2.
- Round-robin stall:
  - o_ptr = 2, lane 2 full, lanes 0, 1, 3 empty, no ack → o_ready = 0 for 5 cycles; then i_ack = 0100 → the held word lands in lane 2 the next cycle and o_ptr = 3.
- Ack semantics:
  - Ack lane 3 while empty → no change.
  - Ack lanes 0 and 3 together while both full → o_valid[0] and o_valid[3] clear; o_out0 and o_out3 retain their data.
